// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one alu_core between NREQ requesters.
// Latency: a command granted in cycle t shows up on rsp_* in cycle t+1.
// Backpressure: no grant while the response slot is full and rsp_ready is low;
//   a consume and a grant in the same cycle keep one result per clock flowing.
// Ports: clk/rst_n (async active-low); req_valid/req_ready per-requester
//   handshake (req_ready one-hot); req_opA/req_opB/req_S/req_M/req_Cin packed
//   commands, requester i at [i*w +: w]; rsp_valid/rsp_ready response handshake
//   with rsp_id, rsp_DO, rsp_flags = {C,V,N,Z}.
// Optional: define ALU_ARB_CHAIN_EN to add req_chain, which locks the ALU to one
//   requester and forwards the carry between beats (multi-word arithmetic).

// alu_core: combinational ALU, zero latency, no flow control.
// M=1 arithmetic: dout = A + Y + Cin, Y = B (S=1001), ~B (S=0110), all-ones
//   (S=1111), else 0.  M=0 logic: each result bit is S[{a_bit,b_bit}].
// Flags {C,V,N,Z}; C and V are 0 for logic operations.
module alu_core #(
  parameter int n = 32
) (
  input  logic [n-1:0] a,
  input  logic [n-1:0] b,
  input  logic [3:0]   s,
  input  logic         m,
  input  logic         cin,
  output logic [n-1:0] dout,
  output logic [3:0]   flags
);
  logic [n-1:0] y;
  logic [n:0]   sum;
  logic         c;
  logic         v;

  always_comb begin
    y    = '0;
    sum  = '0;
    dout = '0;
    c    = 1'b0;
    v    = 1'b0;
    if (m) begin
      case (s)
        4'b1001: y = b;
        4'b0110: y = ~b;
        4'b1111: y = '1;
        default: y = '0;
      endcase
      sum  = {1'b0, a} + {1'b0, y} + {{n{1'b0}}, cin};
      dout = sum[n-1:0];
      c    = sum[n];
      // Signed overflow: both addends share a sign the result does not.
      v    = (a[n-1] == y[n-1]) && (dout[n-1] != a[n-1]);
    end else begin
      // S is the truth table of the bitwise function, indexed by {a,b}.
      for (int i = 0; i < n; i++) dout[i] = s[{a[i], b[i]}];
    end
    flags = {c, v, dout[n-1], (dout == '0)};
  end
endmodule

module alu_arbiter #(
  parameter int n    = 32,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*n-1:0] req_opA,
  input  logic [NREQ*n-1:0] req_opB,
  input  logic [NREQ*4-1:0] req_S,
  input  logic [NREQ-1:0]   req_M,
  input  logic [NREQ-1:0]   req_Cin,
`ifdef ALU_ARB_CHAIN_EN
  input  logic [NREQ-1:0]   req_chain,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [IDW-1:0]    rsp_id,
  output logic [n-1:0]      rsp_DO,
  output logic [3:0]        rsp_flags
);
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] ptr_nxt;
  logic           slot_free;
  logic           gnt_vld;
  logic [IDW-1:0] gnt_id;
  logic [IDW-1:0] idx;
  int             idx_int;

  logic [n-1:0]   alu_a;
  logic [n-1:0]   alu_b;
  logic [3:0]     alu_s;
  logic           alu_m;
  logic           alu_cin;
  logic [n-1:0]   alu_do;
  logic [3:0]     alu_flags;

`ifdef ALU_ARB_CHAIN_EN
  typedef enum logic {ARB, LOCK} state_t;
  state_t         state;
  logic [IDW-1:0] lock_id;
  logic           carry_q;
`endif

  assign slot_free = !rsp_valid || rsp_ready;

  // Grant selection: first valid requester at or above the pointer, wrapping.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    idx_int = 0;
`ifdef ALU_ARB_CHAIN_EN
    if (state == LOCK) begin
      if (req_valid[lock_id]) begin
        gnt_vld = 1'b1;
        gnt_id  = lock_id;
      end
    end else
`endif
    begin
      for (int k = 0; k < NREQ; k++) begin
        idx_int = int'(ptr) + k;
        if (idx_int >= NREQ) idx_int = idx_int - NREQ;
        idx = idx_int[IDW-1:0];
        if (!gnt_vld && req_valid[idx]) begin
          gnt_vld = 1'b1;
          gnt_id  = idx;
        end
      end
    end
    // Reset is folded in so req_ready stays low while rst_n is held.
    if (!slot_free || !rst_n) gnt_vld = 1'b0;
    req_ready = gnt_vld ? (NREQ'(1) << gnt_id) : '0;
  end

  assign ptr_nxt = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;

  // Shared ALU operands, zeroed when nothing is granted.
  always_comb begin
    alu_a   = '0;
    alu_b   = '0;
    alu_s   = '0;
    alu_m   = 1'b0;
    alu_cin = 1'b0;
    if (gnt_vld) begin
      alu_a   = req_opA[int'(gnt_id)*n +: n];
      alu_b   = req_opB[int'(gnt_id)*n +: n];
      alu_s   = req_S[int'(gnt_id)*4 +: 4];
      alu_m   = req_M[gnt_id];
`ifdef ALU_ARB_CHAIN_EN
      alu_cin = (state == LOCK) ? carry_q : req_Cin[gnt_id];
`else
      alu_cin = req_Cin[gnt_id];
`endif
    end
  end

  alu_core #(.n(n)) u_alu (
    .a     (alu_a),
    .b     (alu_b),
    .s     (alu_s),
    .m     (alu_m),
    .cin   (alu_cin),
    .dout  (alu_do),
    .flags (alu_flags)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr       <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_DO    <= '0;
      rsp_flags <= '0;
`ifdef ALU_ARB_CHAIN_EN
      state     <= ARB;
      lock_id   <= '0;
      carry_q   <= 1'b0;
`endif
    end else begin
      if (gnt_vld) begin
        rsp_valid <= 1'b1;
        rsp_id    <= gnt_id;
        rsp_DO    <= alu_do;
        rsp_flags <= alu_flags;
      end else if (rsp_ready) begin
        rsp_valid <= 1'b0;
      end
`ifdef ALU_ARB_CHAIN_EN
      if (gnt_vld) begin
        case (state)
          ARB: begin
            ptr <= ptr_nxt;
            if (req_chain[gnt_id]) begin
              state   <= LOCK;
              lock_id <= gnt_id;
              carry_q <= alu_flags[3];
            end
          end
          LOCK: begin
            // Pointer is frozen while locked; it moves past the owner on exit.
            if (req_chain[gnt_id]) begin
              carry_q <= alu_flags[3];
            end else begin
              state <= ARB;
              ptr   <= ptr_nxt;
            end
          end
          default: state <= ARB;
        endcase
      end
`else
      if (gnt_vld) ptr <= ptr_nxt;
`endif
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
module tb_alu_arbiter;
  localparam int N    = 32;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*N-1:0] req_opA;
  logic [NREQ*N-1:0] req_opB;
  logic [NREQ*4-1:0] req_S;
  logic [NREQ-1:0]   req_M;
  logic [NREQ-1:0]   req_Cin;
`ifdef ALU_ARB_CHAIN_EN
  logic [NREQ-1:0]   req_chain;
`endif
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_DO;
  logic [3:0]        rsp_flags;

  always #5 clk = ~clk;

  alu_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_opA   (req_opA),
    .req_opB   (req_opB),
    .req_S     (req_S),
    .req_M     (req_M),
    .req_Cin   (req_Cin),
`ifdef ALU_ARB_CHAIN_EN
    .req_chain (req_chain),
`endif
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_DO    (rsp_DO),
    .rsp_flags (rsp_flags)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state: pending response and round-robin pointer.
  int          m_ptr;
  bit          m_valid;
  int          m_id;
  logic [31:0] m_do;
  logic [3:0]  m_flags;
  bit          m_lock;
  int          m_lock_id;
  bit          m_carry;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Returns {C,V,N,Z,DO}, computed with wide plain arithmetic.
  function automatic logic [35:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] s, input logic m, input logic cin);
    logic [31:0]     r;
    bit              c;
    bit              v;
    longint          sa;
    longint          sb;
    longint          sy;
    longint          sr;
    longint unsigned ua;
    longint unsigned uy;
    longint unsigned ur;
    c = 0;
    v = 0;
    if (m) begin
      sa = $signed(a);
      sb = $signed(b);
      ua = a;
      case (s)
        4'b1001: begin uy = b;                       sy = sb;      end
        4'b0110: begin uy = 64'hFFFF_FFFF - b;        sy = -sb - 1; end
        4'b1111: begin uy = 64'hFFFF_FFFF;            sy = -1;      end
        default: begin uy = 0;                        sy = 0;       end
      endcase
      ur = ua + uy + cin;
      sr = sa + sy + cin;
      r  = ur[31:0];
      c  = ur[32];
      v  = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    end else begin
      r = (s[3] ? (a & b) : 32'h0) | (s[2] ? (a & ~b) : 32'h0) |
          (s[1] ? (~a & b) : 32'h0) | (s[0] ? (~a & ~b) : 32'h0);
    end
    return {c, v, r[31], (r == 32'h0), r};
  endfunction

  function automatic int model_grant();
    if (m_valid && !rsp_ready) return -1;
    if (m_lock) return req_valid[m_lock_id] ? m_lock_id : -1;
    for (int k = 0; k < NREQ; k++) begin
      if (req_valid[(m_ptr + k) % NREQ]) return (m_ptr + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_ptr     = 0;
    m_valid   = 0;
    m_id      = 0;
    m_do      = 0;
    m_flags   = 0;
    m_lock    = 0;
    m_lock_id = 0;
    m_carry   = 0;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] s, input logic m, input logic cin);
    req_opA[i*N +: N] = a;
    req_opB[i*N +: N] = b;
    req_S[i*4 +: 4]   = s;
    req_M[i]          = m;
    req_Cin[i]        = cin;
  endtask

  // One clock: check the grant before the edge, advance the model, check rsp_* after.
  task automatic cycle();
    int            g;
    logic          cin;
    logic [35:0]   res;
    logic [NREQ-1:0] exp_rdy;
    bit            chain_bit;
    #1;
    g = model_grant();
    exp_rdy = (g < 0) ? '0 : (NREQ'(1) << g);
    chk("req_ready", req_ready, exp_rdy);
    res = '0;
    chain_bit = 0;
    if (g >= 0) begin
      cin = m_lock ? m_carry : req_Cin[g];
      res = ref_alu(req_opA[g*N +: N], req_opB[g*N +: N], req_S[g*4 +: 4], req_M[g], cin);
`ifdef ALU_ARB_CHAIN_EN
      chain_bit = req_chain[g];
`endif
    end
    @(posedge clk);
    if (g >= 0) begin
      m_valid = 1;
      m_id    = g;
      m_do    = res[31:0];
      m_flags = res[35:32];
      if (m_lock) begin
        if (!chain_bit) begin
          m_lock = 0;
          m_ptr  = (g + 1) % NREQ;
        end else begin
          m_carry = res[35];
        end
      end else begin
        m_ptr = (g + 1) % NREQ;
        if (chain_bit) begin
          m_lock    = 1;
          m_lock_id = g;
          m_carry   = res[35];
        end
      end
    end else if (rsp_ready) begin
      m_valid = 0;
    end
    #1;
    chk("rsp_valid", rsp_valid, m_valid);
    if (m_valid) begin
      chk("rsp_id", rsp_id, m_id);
      chk("rsp_DO", rsp_DO, m_do);
      chk("rsp_flags", rsp_flags, m_flags);
    end
  endtask

  task automatic randomize_ops();
    logic [3:0] s;
    for (int i = 0; i < NREQ; i++) begin
      case ($urandom_range(0, 3))
        0: s = 4'b1001;
        1: s = 4'b0110;
        2: s = 4'b1111;
        default: s = 4'($urandom);
      endcase
      set_req(i, $urandom, $urandom, s, 1'($urandom), 1'($urandom));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '1;
    req_opA   = '0;
    req_opB   = '0;
    req_S     = '0;
    req_M     = '0;
    req_Cin   = '0;
    rsp_ready = 1'b1;
`ifdef ALU_ARB_CHAIN_EN
    req_chain = '0;
`endif
    model_reset();

    // Reset state
    #3;
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_id", rsp_id, 0);
    chk("rst_rsp_DO", rsp_DO, 0);
    chk("rst_rsp_flags", rsp_flags, 0);
    chk("rst_req_ready", req_ready, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Round-robin fairness: all valid, consumer always ready
    req_valid = '1;
    for (int k = 0; k < 6; k++) begin
      randomize_ops();
      #1;
      chk("rr_order", req_ready, NREQ'(1) << (k % NREQ));
      cycle();
    end

    // Single add from requester 2
    req_valid = 4'b0100;
    set_req(2, 32'h0101_0000, 32'h1010_0101, 4'b1001, 1'b1, 1'b0);
    cycle();
    chk("add_DO", rsp_DO, 32'h1111_0101);
    chk("add_id", rsp_id, 2);
    chk("add_vnz", rsp_flags[2:0], 3'b000);

    // Backpressure after a subtract from requester 1
    req_valid = 4'b0010;
    set_req(1, 32'h8000_0000, 32'h0000_0001, 4'b0110, 1'b1, 1'b1);
    cycle();
    rsp_ready = 1'b0;
    req_valid = '1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      chk("bp_DO", rsp_DO, 32'h7FFF_FFFF);
      chk("bp_V", rsp_flags[2], 1'b1);
      chk("bp_ready", req_ready, 0);
    end
    rsp_ready = 1'b1;
    req_valid = '0;
    #1;
    chk("bp_held_DO", rsp_DO, 32'h7FFF_FFFF);
    cycle();

    // Logic operations from requester 3
    req_valid = 4'b1000;
    set_req(3, 32'hF05A_F05A, 32'h0FA5_F05A, 4'b0110, 1'b0, 1'b0);
    cycle();
    chk("xor_DO", rsp_DO, 32'hFFFF_0000);
    chk("xor_N", rsp_flags[1], 1'b1);
    chk("xor_Z", rsp_flags[0], 1'b0);
    set_req(3, 32'hF05A_F05A, 32'h0FA5_F05A, 4'b0000, 1'b0, 1'b0);
    cycle();
    chk("zero_DO", rsp_DO, 32'h0);
    chk("zero_Z", rsp_flags[0], 1'b1);

`ifdef ALU_ARB_CHAIN_EN
    // Move the pointer to 1, then a two-beat 64-bit add with req 0 competing
    req_valid = 4'b0001;
    cycle();
    req_valid = 4'b0011;
    set_req(0, 32'h1234_5678, 32'h1, 4'b1001, 1'b1, 1'b0);
    set_req(1, 32'hFFFF_FFFF, 32'h1, 4'b1001, 1'b1, 1'b0);
    req_chain = 4'b0010;
    cycle();
    chk("chain1_DO", rsp_DO, 32'h0);
    chk("chain1_C", rsp_flags[3], 1'b1);
    set_req(1, 32'h0, 32'h0, 4'b1001, 1'b1, 1'b0);
    req_chain = 4'b0000;
    #1;
    chk("chain2_grant", req_ready, 4'b0010);
    cycle();
    chk("chain2_DO", rsp_DO, 32'h1);
    chk("chain2_id", rsp_id, 1);
`endif

    // Randomized traffic against the model
    for (int k = 0; k < 400; k++) begin
      req_valid = NREQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
      randomize_ops();
`ifdef ALU_ARB_CHAIN_EN
      for (int i = 0; i < NREQ; i++) req_chain[i] = ($urandom_range(0, 3) == 0);
`endif
      cycle();
    end

    // Mid-stream asynchronous reset with a response pending
    req_valid = '1;
    rsp_ready = 1'b1;
`ifdef ALU_ARB_CHAIN_EN
    req_chain = '0;
`endif
    randomize_ops();
    cycle();
    rsp_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", rsp_valid, 0);
    chk("mid_rst_DO", rsp_DO, 0);
    chk("mid_rst_flags", rsp_flags, 0);
    chk("mid_rst_id", rsp_id, 0);
    chk("mid_rst_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1'b1;
    rsp_ready = 1'b1;
    #1;
    chk("post_rst_grant", req_ready, 4'b0001);
    cycle();
    cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Round-robin arbiter that shares one `alu_core` instance between NREQ requesters. Each requester presents a full ALU command: opA, opB, S, M, Cin. The arbiter grants at most one command per clock and drives the shared `alu_core` combinationally. It registers DO and the C/V/N/Z flags into a one-entry response stage with valid/ready backpressure, tagged with the requester id.

Parameters:
- n, 32, ALU datapath width, passed to `alu_core`.
- NREQ, 4, number of requesters (2..8).
- IDW, 2, response id width; must satisfy 2**IDW >= NREQ.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  NREQ  per-requester command valid.
- req_ready  output  NREQ  one-hot grant; a command transfers when req_valid[i] && req_ready[i].
- req_opA  input  NREQ*n  packed operand A; requester i occupies bits [i*n +: n].
- req_opB  input  NREQ*n  packed operand B.
- req_S  input  NREQ*4  packed function select.
- req_M  input  NREQ  mode: 1 = arithmetic, 0 = logic.
- req_Cin  input  NREQ  carry in.
- rsp_valid  output  1  response register holds a result.
- rsp_ready  input  1  consumer accepts the response.
- rsp_id  output  IDW  index of the requester that produced the result.
- rsp_DO  output  n  registered `alu_core` DO.
- rsp_flags  output  4  registered {C,V,N,Z}.

Behaviour:
- Reset, asserted asynchronously:
  - rsp_valid=0; rsp_id, rsp_DO and rsp_flags all 0.
  - Round-robin pointer = 0; lock cleared.
  - req_ready=0 while rst_n=0.
- Slot free condition: slot_free = !rsp_valid || rsp_ready. No grant is issued when slot_free=0.
- Arbitration:
  - Grant goes to the first i with req_valid[i], scanning from the pointer upward and wrapping at NREQ-1 to 0.
  - req_ready is combinational, one-hot or all-zero, and never asserted for a requester whose valid is low.
- Pointer update: after a grant to i, pointer = (i+1) mod NREQ. With no grant, the pointer holds.
- Datapath: the `alu_core` inputs are muxed from the granted requester; with no grant they are driven to 0.
- Latency: a grant in cycle t gives rsp_valid=1 with the result in cycle t+1.
- Response register:
  - Loads on every grant.
  - Clears rsp_valid when rsp_ready && rsp_valid and there is no grant in the same cycle.
  - Simultaneous consume and grant: the register reloads and rsp_valid stays 1. This gives full throughput of one result per clock.
- Stall: while rsp_valid && !rsp_ready, rsp_* outputs are stable and req_ready=0.
- Flags are passed through unmodified from `alu_core`. No flag recomputation is done here.
- FSM has two states:
  - ARB: normal round-robin.
  - LOCK: only valid with the optional feature; see below.
  - Without the macro the FSM is fixed in ARB.
- A requester's valid dropping without a handshake is legal; the request is simply not granted.

Optional Feature:
- Macro: ALU_ARB_CHAIN_EN.
- Defined:
  - Adds input port req_chain [NREQ-1:0].
  - A granted beat with req_chain[i]=1 moves the FSM ARB->LOCK(i) and stores that beat's C flag in carry_q.
  - In LOCK(i), only requester i can be granted, and the ALU Cin = carry_q (req_Cin[i] is ignored).
  - The pointer does not advance in LOCK.
  - A granted beat in LOCK with req_chain[i]=0 returns the FSM to ARB and sets pointer = (i+1) mod NREQ.
  - Reset in LOCK returns the FSM to ARB.
- Not defined: no req_chain port, no carry_q, and every beat is arbitrated independently.

Test Plan:
- Reset sequencing: rst_n=0 mid-stream with rsp_valid=1 -> rsp_valid=0, all rsp_* outputs 0 immediately (asynchronously); the first grant after release goes to requester 0 when all are valid.
- Single add: req 2 sends opA=0x0101_0000, opB=0x1010_0101, S=1001, M=1, Cin=0 -> next cycle rsp_valid=1, rsp_id=2, rsp_DO=0x1111_0101, V=0, N=0, Z=0.
- Round-robin fairness: all four requesters held valid, rsp_ready=1 -> grants 0,1,2,3,0,1 on consecutive cycles, with one response per cycle.
- Backpressure: rsp_ready=0 for 3 cycles after a sub from req 1 (opA=0x8000_0000, opB=0x0000_0001, S=0110, M=1, Cin=1) -> rsp_DO=0x7FFF_FFFF and V=1 held stable, req_ready=0 throughout; no result is lost after rsp_ready rises.
- Logic op: req 3 sends S=0110, M=0, opA=0xF05A_F05A, opB=0x0FA5_F05A -> rsp_DO=0xFFFF_0000, N=1, Z=0; S=0000 with the same operands -> rsp_DO=0, Z=1.
- With ALU_ARB_CHAIN_EN, 64-bit add from req 1 while req 0 is also valid:
  - Beat 1: opA=0xFFFF_FFFF, opB=1, Cin=0, chain=1 -> DO=0, C=1.
  - Beat 2: opA=0, opB=0, chain=0 -> DO=0x0000_0001.
  - req 0 is not granted between the two beats.
